// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder array: decode step
// encoding, the Gray position table and signed saturation.
package quad_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_INC,
        STEP_DEC,
        STEP_ILLEGAL
    } step_e;

    // AB codes in forward order; position index i+1 is one +1 step after i.
    localparam logic [1:0] GRAY_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        gray_pos = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (GRAY_SEQ[i] == ab) gray_pos = 2'(i);
        end
    endfunction

    function automatic step_e decode_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] delta;
        delta = gray_pos(cur_ab) - gray_pos(prev_ab);
        case (delta)
            2'd0:    decode_step = STEP_NONE;
            2'd1:    decode_step = STEP_INC;
            2'd3:    decode_step = STEP_DEC;
            default: decode_step = STEP_ILLEGAL;
        endcase
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (value > max_v)      sat_signed = max_v;
        else if (value < min_v) sat_signed = min_v;
        else                    sat_signed = value;
    endfunction

endpackage

// File: rtl/quad_channel.sv
// One encoder channel: 2-FF sync, per-bit stability filter, x4 decode,
// wrapping position counter, sticky error flag and velocity snapshot.
module quad_channel #(
    parameter int COUNT_W    = 32,
    parameter int VEL_W      = 16,
    parameter int FILTER_LEN = 5
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               a_i,
    input  logic               b_i,
    input  logic               clear_i,
    input  logic               err_clr_i,
    input  logic               sample_i,
    output logic [COUNT_W-1:0] count_o,
    output logic [VEL_W-1:0]   velocity_o,
    output logic               direction_o,
    output logic               error_o
);
    import quad_pkg::*;

    localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);

    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         filt_q, filt_d, prev_q;
    logic [FCNT_W-1:0]  fcnt_q [2];
    logic [FCNT_W-1:0]  fcnt_d [2];
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] snap_q, snap_d, diff;
    logic [VEL_W-1:0]   vel_q, vel_d;
    logic               dir_q, dir_d, err_q, err_d;
    step_e              step;

    // A filtered bit only follows the synced bit after FILTER_LEN consecutive
    // cycles of disagreement; any agreement restarts the count.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        filt_d = filt_q;
        for (int b = 0; b < 2; b++) begin
            fcnt_d[b] = '0;
            if (sync2_q[b] != filt_q[b]) begin
                if (fcnt_q[b] == FCNT_LAST) filt_d[b] = sync2_q[b];
                else                        fcnt_d[b] = fcnt_q[b] + FCNT_W'(1);
            end
        end
    end

    always_comb begin
        step    = decode_step(prev_q, filt_q);
        count_d = count_q;
        dir_d   = dir_q;
        err_d   = err_q;
        unique case (step)
            STEP_INC:     begin count_d = count_q + COUNT_W'(1); dir_d = 1'b1; end
            STEP_DEC:     begin count_d = count_q - COUNT_W'(1); dir_d = 1'b0; end
            STEP_ILLEGAL: err_d = 1'b1;
            STEP_NONE:    ;
        endcase
        if (err_clr_i && step != STEP_ILLEGAL) err_d = 1'b0;
        if (clear_i) count_d = '0;

        // Modular subtraction gives the right signed delta across a wrap.
        diff   = count_d - snap_q;
        snap_d = snap_q;
        vel_d  = vel_q;
        if (sample_i) begin
            snap_d = count_d;
            vel_d  = clear_i ? '0 : VEL_W'(sat_signed(64'($signed(diff)), VEL_W));
        end else if (clear_i) begin
            snap_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            prev_q  <= '0;
            fcnt_q  <= '{default: '0};
            count_q <= '0;
            snap_q  <= '0;
            vel_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
            count_q <= count_d;
            snap_q  <= snap_d;
            vel_q   <= vel_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign count_o     = count_q;
    assign velocity_o  = vel_q;
    assign direction_o = dir_q;
    assign error_o     = err_q;

endmodule

// File: rtl/quad_encoder_array.sv
// NUM_CH independent quadrature channels sharing one velocity timebase and a
// common vel_valid strobe.
module quad_encoder_array #(
    parameter int NUM_CH     = 2,
    parameter int COUNT_W    = 32,
    parameter int VEL_W      = 16,
    parameter int FILTER_LEN = 5,
    parameter int VEL_PERIOD = 16000
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         quadA,
    input  logic [NUM_CH-1:0]         quadB,
    input  logic [NUM_CH-1:0]         clear,
    input  logic [NUM_CH-1:0]         err_clr,
    output logic [NUM_CH*COUNT_W-1:0] count,
    output logic [NUM_CH*VEL_W-1:0]   velocity,
    output logic                      vel_valid,
    output logic [NUM_CH-1:0]         direction,
    output logic [NUM_CH-1:0]         error
);
    localparam int TB_W = (VEL_PERIOD > 1) ? $clog2(VEL_PERIOD) : 1;

    logic [TB_W-1:0] tb_q, tb_d;
    logic            sample;
    logic            vel_valid_q;

    assign sample = (tb_q == TB_W'(VEL_PERIOD - 1));
    assign tb_d   = sample ? '0 : tb_q + TB_W'(1);

    always_ff @(posedge CLK) begin
        if (!reset) begin
            tb_q        <= '0;
            vel_valid_q <= 1'b0;
        end else begin
            tb_q        <= tb_d;
            vel_valid_q <= sample;
        end
    end

    assign vel_valid = vel_valid_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        quad_channel #(
            .COUNT_W    (COUNT_W),
            .VEL_W      (VEL_W),
            .FILTER_LEN (FILTER_LEN)
        ) u_ch (
            .clk_i       (CLK),
            .rst_n_i     (reset),
            .a_i         (quadA[i]),
            .b_i         (quadB[i]),
            .clear_i     (clear[i]),
            .err_clr_i   (err_clr[i]),
            .sample_i    (sample),
            .count_o     (count[i*COUNT_W +: COUNT_W]),
            .velocity_o  (velocity[i*VEL_W +: VEL_W]),
            .direction_o (direction[i]),
            .error_o     (error[i])
        );
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: 2 channels, 8-bit count, 4-bit
// velocity, FILTER_LEN 5, 100-cycle velocity window.
module tb_quad_encoder_array;
    localparam int NUM_CH     = 2;
    localparam int COUNT_W    = 8;
    localparam int VEL_W      = 4;
    localparam int FILTER_LEN = 5;
    localparam int VEL_PERIOD = 100;

    localparam logic [1:0] GRAY [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    logic                      CLK = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         quadA, quadB, clear, err_clr;
    logic [NUM_CH*COUNT_W-1:0] count;
    logic [NUM_CH*VEL_W-1:0]   velocity;
    logic                      vel_valid;
    logic [NUM_CH-1:0]         direction, error;

    int         checks = 0;
    int         errors = 0;
    int         n;
    logic [1:0] pos [NUM_CH];

    quad_encoder_array #(
        .NUM_CH     (NUM_CH),
        .COUNT_W    (COUNT_W),
        .VEL_W      (VEL_W),
        .FILTER_LEN (FILTER_LEN),
        .VEL_PERIOD (VEL_PERIOD)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .quadA     (quadA),
        .quadB     (quadB),
        .clear     (clear),
        .err_clr   (err_clr),
        .count     (count),
        .velocity  (velocity),
        .vel_valid (vel_valid),
        .direction (direction),
        .error     (error)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cycles);
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic drive(input int ch, input logic [1:0] ab);
        quadA[ch] = ab[1];
        quadB[ch] = ab[0];
    endtask

    task automatic step(input int ch, input bit fwd, input int gap);
        pos[ch] = fwd ? pos[ch] + 2'd1 : pos[ch] - 2'd1;
        drive(ch, GRAY[pos[ch]]);
        tick(gap);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (vel_valid !== 1'b1 && cycles < 2 * VEL_PERIOD) begin
            tick(1);
            cycles++;
        end
    endtask

    function automatic logic [COUNT_W-1:0] cnt(input int ch);
        return count[ch*COUNT_W +: COUNT_W];
    endfunction

    function automatic logic [VEL_W-1:0] vel(input int ch);
        return velocity[ch*VEL_W +: VEL_W];
    endfunction

    initial begin
        reset   = 1'b0;
        quadA   = '0;
        quadB   = '0;
        clear   = '0;
        err_clr = '0;
        pos[0]  = 2'd0;
        pos[1]  = 2'd0;
        tick(3);
        check("reset_count", count, 32'h0);
        check("reset_velocity", velocity, 32'h0);
        check("reset_vel_valid", vel_valid, 32'h0);
        check("reset_direction", direction, 32'h0);
        check("reset_error", error, 32'h0);
        reset = 1'b1;
        tick(5);

        // Forward then reverse on channel 0
        repeat (8) step(0, 1'b1, 40);
        check("fwd_count", cnt(0), 32'h08);
        check("fwd_dir", direction[0], 32'h1);
        check("fwd_err", error[0], 32'h0);
        repeat (3) step(0, 1'b0, 40);
        check("rev_count", cnt(0), 32'h05);
        check("rev_dir", direction[0], 32'h0);

        // Glitch rejection from AB=01: a 4-cycle A pulse is dropped, a 6-cycle one passes
        quadA[0] = 1'b1;
        tick(4);
        quadA[0] = 1'b0;
        tick(20);
        check("glitch4_count", cnt(0), 32'h05);
        quadA[0] = 1'b1;
        tick(6);
        quadA[0] = 1'b0;
        tick(1);
        check("glitch6_before", cnt(0), 32'h05);
        tick(1);
        check("glitch6_step", cnt(0), 32'h06);
        check("glitch6_dir", direction[0], 32'h1);
        tick(20);
        check("glitch6_return", cnt(0), 32'h05);

        // Illegal jump 00->11, err_clr, then set-wins on a 01->10 jump
        step(0, 1'b0, 20);
        check("pre_illegal_count", cnt(0), 32'h04);
        drive(0, 2'b11);
        pos[0] = 2'd2;
        tick(20);
        check("illegal_count", cnt(0), 32'h04);
        check("illegal_err", error[0], 32'h1);
        check("illegal_dir_hold", direction[0], 32'h0);
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        check("errclr", error[0], 32'h0);
        step(0, 1'b0, 20);
        check("after_errclr_count", cnt(0), 32'h03);
        drive(0, 2'b10);
        pos[0] = 2'd3;
        tick(7);
        check("pre_jump_err", error[0], 32'h0);
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        check("set_wins_err", error[0], 32'h1);
        check("jump_count", cnt(0), 32'h03);
        tick(10);
        err_clr[0] = 1'b1;
        tick(1);
        err_clr[0] = 1'b0;
        check("errclr2", error[0], 32'h0);

        // Wrap at 8 bits
        clear[0] = 1'b1;
        tick(1);
        clear[0] = 1'b0;
        check("clear_zero", cnt(0), 32'h00);
        repeat (127) step(0, 1'b1, 8);
        check("preload_127", cnt(0), 32'h7F);
        step(0, 1'b1, 10);
        check("wrap_pos", cnt(0), 32'h80);
        clear[0] = 1'b1;
        tick(1);
        clear[0] = 1'b0;
        step(0, 1'b0, 10);
        check("wrap_neg", cnt(0), 32'hFF);
        check("wrap_neg_dir", direction[0], 32'h0);

        // Clear coincident with a +1 step; channel 1 independent
        repeat (3) step(1, 1'b1, 10);
        check("ch1_count", cnt(1), 32'h03);
        check("ch0_untouched", cnt(0), 32'hFF);
        step(0, 1'b1, 10);
        step(0, 1'b1, 10);
        pos[0] = pos[0] + 2'd1;
        drive(0, GRAY[pos[0]]);
        tick(7);
        check("pre_clear_count", cnt(0), 32'h01);
        clear[0] = 1'b1;
        tick(1);
        clear[0] = 1'b0;
        check("clear_wins", cnt(0), 32'h00);
        tick(10);
        check("clear_step_dropped", cnt(0), 32'h00);
        check("clear_ch1", cnt(1), 32'h03);

        // Velocity windows: 5, +20 (saturates to 7), -20 (saturates to -8)
        wait_valid(n);
        check("vv_seen0", vel_valid, 32'h1);
        repeat (5) step(0, 1'b1, 8);
        wait_valid(n);
        check("vv_seen1", vel_valid, 32'h1);
        check("vel_5", vel(0), 32'h5);
        check("vel_ch1_0", vel(1), 32'h0);
        tick(1);
        check("vv_pulse", vel_valid, 32'h0);
        repeat (20) step(0, 1'b1, 4);
        wait_valid(n);
        check("vv_seen2", vel_valid, 32'h1);
        check("vel_sat_pos", vel(0), 32'h7);
        tick(1);
        repeat (20) step(0, 1'b0, 4);
        wait_valid(n);
        check("vv_seen3", vel_valid, 32'h1);
        check("vel_sat_neg", vel(0), 32'h8);
        check("vel_count", cnt(0), 32'h05);

        // Reset mid-window, then first vel_valid exactly VEL_PERIOD cycles after release
        tick(30);
        reset = 1'b0;
        tick(1);
        check("midrst_count", count, 32'h0);
        check("midrst_velocity", velocity, 32'h0);
        check("midrst_vel_valid", vel_valid, 32'h0);
        check("midrst_direction", direction, 32'h0);
        check("midrst_error", error, 32'h0);
        quadA  = '0;
        quadB  = '0;
        pos[0] = 2'd0;
        pos[1] = 2'd0;
        tick(2);
        reset = 1'b1;
        wait_valid(n);
        check("first_valid_latency", n, VEL_PERIOD);
        check("post_rst_count", count, 32'h0);
        check("post_rst_vel", velocity, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
